// File: rtl/btn_event.sv
// Turns a debounced button level into single-cycle PRESS/RELEASE/LONG/REPEAT
// pulses, plus a held level and a wrapping press counter.
module btn_event #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned LONG_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_LVL,
  output logic       PRESS,
  output logic       RELEASE,
  output logic       LONG,
  output logic       REPEAT,
  output logic       HELD,
  output logic [7:0] PRESS_CNT
);

  localparam int unsigned PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MAX_TICK = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned TICK_W   = $clog2(MAX_TICK + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  LONG_LAST   = TICK_W'(LONG_TICKS - 1);
  localparam logic [TICK_W-1:0]  REPEAT_LAST = TICK_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               btn_q;
  logic [PRESC_W-1:0] presc, presc_nxt, presc_adv;
  logic [TICK_W-1:0]  tick, tick_nxt, tick_adv;
  logic               press_nxt, release_nxt, long_nxt, repeat_nxt, held_nxt;
  logic [7:0]         cnt_nxt;
  logic               rise, fall, wrap;

  assign rise = BTN_LVL & ~btn_q;
  assign fall = ~BTN_LVL & btn_q;

  // Prescaler advance; the tick counter steps on each prescaler wrap.
  assign wrap      = (presc == PRESC_LAST);
  assign presc_adv = wrap ? '0 : presc + PRESC_W'(1);
  assign tick_adv  = wrap ? tick + TICK_W'(1) : tick;

  // Registered state, counters and outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      btn_q     <= 1'b0;
      presc     <= '0;
      tick      <= '0;
      PRESS     <= 1'b0;
      RELEASE   <= 1'b0;
      LONG      <= 1'b0;
      REPEAT    <= 1'b0;
      HELD      <= 1'b0;
      PRESS_CNT <= 8'd0;
    end else begin
      state     <= state_nxt;
      btn_q     <= BTN_LVL;
      presc     <= presc_nxt;
      tick      <= tick_nxt;
      PRESS     <= press_nxt;
      RELEASE   <= release_nxt;
      LONG      <= long_nxt;
      REPEAT    <= repeat_nxt;
      HELD      <= held_nxt;
      PRESS_CNT <= cnt_nxt;
    end
  end

  // Next-state and event decode; a release always wins over a timed event.
  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc;
    tick_nxt    = tick;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    cnt_nxt     = PRESS_CNT;

    case (state)
      IDLE: begin
        if (rise) begin
          press_nxt = 1'b1;
          cnt_nxt   = PRESS_CNT + 8'd1;
          state_nxt = PRESSED;
          presc_nxt = '0;
          tick_nxt  = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_nxt = 1'b1;
          state_nxt   = IDLE;
          presc_nxt   = '0;
          tick_nxt    = '0;
        end else if (wrap && (tick == LONG_LAST)) begin
          long_nxt  = 1'b1;
          state_nxt = LONG_HELD;
          presc_nxt = '0;
          tick_nxt  = '0;
        end else begin
          presc_nxt = presc_adv;
          tick_nxt  = tick_adv;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          release_nxt = 1'b1;
          state_nxt   = IDLE;
          presc_nxt   = '0;
          tick_nxt    = '0;
        end else if (wrap && (tick == REPEAT_LAST)) begin
          repeat_nxt = 1'b1;
          presc_nxt  = '0;
          tick_nxt   = '0;
        end else begin
          presc_nxt = presc_adv;
          tick_nxt  = tick_adv;
        end
      end
      default: begin
        state_nxt = IDLE;
        presc_nxt = '0;
        tick_nxt  = '0;
      end
    endcase

    held_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_btn_event.sv
// Randomized and directed bench for btn_event against a timing-arithmetic model.
module tb_btn_event;

  localparam int unsigned TD = 4;
  localparam int unsigned LT = 3;
  localparam int unsigned RT = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       BTN_LVL = 1'b0;
  logic       PRESS, RELEASE, LONG, REPEAT, HELD;
  logic [7:0] PRESS_CNT;

  int n_cmp = 0;
  int n_err = 0;

  // Model: pulse timing derived from cycles elapsed since the PRESS edge.
  int   cyc = 0;
  int   m_pedge = 0;
  bit   m_prev = 1'b0;
  bit   m_hold = 1'b0;
  int   m_cnt = 0;
  int   n_press = 0;
  int   n_release = 0;

  btn_event #(.TICK_DIV(TD), .LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
    .CLK(CLK), .RST(RST), .BTN_LVL(BTN_LVL),
    .PRESS(PRESS), .RELEASE(RELEASE), .LONG(LONG), .REPEAT(REPEAT),
    .HELD(HELD), .PRESS_CNT(PRESS_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({PRESS, RELEASE, LONG, REPEAT, HELD, PRESS_CNT});
  endfunction

  // One clock: drive b, predict the registered outputs, sample 1 ns after the edge.
  task automatic step(input bit b, input string tag);
    bit e_p, e_r, e_l, e_rp;
    int t;
    e_p = 0; e_r = 0; e_l = 0; e_rp = 0;
    cyc++;
    if (!m_hold) begin
      if (b && !m_prev) begin
        e_p = 1; m_hold = 1; m_pedge = cyc; m_cnt = (m_cnt + 1) % 256;
      end
    end else if (!b) begin
      e_r = 1; m_hold = 0;
    end else begin
      t = cyc - m_pedge;
      if (t == int'(TD * LT)) e_l = 1;
      else if (t > int'(TD * LT) && ((t - int'(TD * LT)) % int'(TD * RT)) == 0) e_rp = 1;
    end
    m_prev = b;
    BTN_LVL = b;
    @(posedge CLK);
    #1;
    check(tag, dut_vec(), 32'({e_p, e_r, e_l, e_rp, m_hold, 8'(m_cnt)}));
    check({tag, "_onehot"}, 32'($countones({PRESS, RELEASE, LONG, REPEAT}) <= 1), 32'd1);
    if (PRESS) n_press++;
    if (RELEASE) n_release++;
  endtask

  // Reset with BTN_LVL held at b; outputs must clear asynchronously.
  task automatic do_reset(input bit b);
    BTN_LVL = b;
    RST = 1'b0;
    #1;
    check("rst_async", dut_vec(), 32'd0);
    @(posedge CLK);
    #1;
    check("rst_hold", dut_vec(), 32'd0);
    m_prev = 0; m_hold = 0; m_cnt = 0;
    RST = 1'b1;
  endtask

  initial begin
    do_reset(1'b0);

    // Long hold: PRESS, LONG at +12, REPEAT every 8 after that
    for (int i = 0; i < 9; i++) step(1'b0, "t1_idle");
    for (int i = 0; i < 45; i++) step(1'b1, "t1_hold");
    step(1'b0, "t1_rel");

    // Short hold of 5 cycles
    step(1'b1, "t2_press");
    for (int i = 0; i < 4; i++) step(1'b1, "t2_hold");
    step(1'b0, "t2_rel");

    // Release on the LONG edge: only RELEASE
    step(1'b1, "t3_press");
    for (int i = 0; i < 11; i++) step(1'b1, "t3_hold");
    step(1'b0, "t3_rel");
    step(1'b0, "t3_idle");

    // Held through reset, then reset while in LONG_HELD
    do_reset(1'b1);
    step(1'b1, "t4_press");
    for (int i = 0; i < 20; i++) step(1'b1, "t4_hold");
    do_reset(1'b1);
    step(1'b1, "t4_repress");
    step(1'b0, "t4_rel");

    // 257 press/release pairs
    do_reset(1'b0);
    n_press = 0; n_release = 0;
    for (int i = 0; i < 257; i++) begin
      step(1'b1, "t5_p");
      step(1'b0, "t5_r");
    end
    check("t5_cnt_wrap", 32'(PRESS_CNT), 32'd1);
    check("t5_n_press", 32'(n_press), 32'd257);
    check("t5_n_release", 32'(n_release), 32'd257);

    // Back-to-back single-cycle pulses
    for (int i = 0; i < 8; i++) step(1'(i % 2 == 0), "t6_alt");

    // Random holds/gaps with occasional resets
    for (int s = 0; s < 300; s++) begin
      int hl, gl;
      if ($urandom_range(24, 0) == 0) do_reset(1'($urandom_range(1, 0)));
      hl = $urandom_range(40, 1);
      gl = $urandom_range(4, 1);
      for (int i = 0; i < hl; i++) step(1'b1, "rnd_hold");
      for (int i = 0; i < gl; i++) step(1'b0, "rnd_gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
